// File: rtl/button_pkg.sv
// Shared constants and channel state encoding for the button accumulator.
package button_pkg;

    localparam int unsigned SyncStages = 2;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE         = 2'd0;
    localparam btn_state_t PRESS_WAIT   = 2'd1;
    localparam btn_state_t HELD         = 2'd2;
    localparam btn_state_t RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, press/release debounce FSM and optional
// auto-repeat (macro AUTO_REPEAT_EN).
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 100,
    parameter int unsigned REPEAT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES);

    logic [SyncStages-1:0] sync_q;
    logic                  btn_s;
    btn_state_t            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  press_q, press_d;
    logic                  rep_fire;

    assign btn_s   = sync_q[SyncStages-1];
    assign press_o = press_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] rep_q, rep_d;

    // Counter only runs while the FSM stays in HELD; any exit clears it.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == HELD && btn_s) begin
            if (rep_q == RepLast) begin
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = rep_fire;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CntW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/multi_button_accumulator.sv
// Debounced multi-button weighted accumulator with saturation.
// Optional auto-repeat while held is enabled by macro AUTO_REPEAT_EN.
module multi_button_accumulator
    import button_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned DEB_CYCLES    = 100,
    parameter int unsigned ACC_W         = 8,
    parameter int unsigned REPEAT_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       btn_in,
    input  logic [NUM_CH*ACC_W-1:0] weight,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       press_pulse,
    output logic [ACC_W-1:0]        acc_out,
    output logic                    acc_valid,
    output logic                    sat
);

    // Wide enough for the accumulator plus every channel's weight at once.
    localparam int unsigned SumW = ACC_W + $clog2(NUM_CH) + 1;
    localparam logic [ACC_W-1:0] AccMax = '1;

    logic [SumW-1:0]  sum, total;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .btn_i  (btn_in[i]),
            .press_o(press_pulse[i])
        );
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (press_pulse[i]) begin
                sum = sum + SumW'(weight[i*ACC_W +: ACC_W]);
            end
        end
        total = sum + SumW'(acc_q);
    end

    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        if (clear) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (|press_pulse) begin
            valid_d = 1'b1;
            if (total > SumW'(AccMax)) begin
                acc_d = AccMax;
                sat_d = 1'b1;
            end else begin
                acc_d = total[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = valid_q;
    assign sat       = sat_q;

endmodule

// File: doc/multi_button_accumulator.md
MULTI_BUTTON_ACCUMULATOR -- requirements
Module: multi_button_accumulator

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of button channels (1..8).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 100: stable cycles required for press and release (>=2).
REQ-003 The block SHALL have parameter ACC_W, default 8: accumulator and weight width (4..32).
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 50_000_000: auto-repeat period in cycles (used only with AUTO_REPEAT_EN).
REQ-005 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-006 The block SHALL have port resetn, input, 1: synchronous active-low reset.
REQ-007 The block SHALL have port btn_in, input, NUM_CH: raw asynchronous button levels, active high.
REQ-008 The block SHALL have port weight, input, NUM_CH*ACC_W: per-channel increment, channel i at bits [i*ACC_W +: ACC_W], quasi-static.
REQ-009 The block SHALL have port clear, input, 1: synchronous accumulator clear.
REQ-010 The block SHALL have port press_pulse, output, NUM_CH: one-cycle pulse per debounced press (or repeat) event.
REQ-011 The block SHALL have port acc_out, output, ACC_W: registered accumulator value.
REQ-012 The block SHALL have port acc_valid, output, 1: one-cycle strobe when acc_out changed by an add.
REQ-013 The block SHALL have port sat, output, 1: sticky saturation flag.

Function
REQ-014 Each channel SHALL pass btn_in through a 2-flop synchroniser before any other logic.
REQ-015 Each channel SHALL run FSM IDLE -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> IDLE with a per-channel counter of width $clog2(DEB_CYCLES+1).
REQ-016 IDLE: synchronised high -> PRESS_WAIT, counter=1; low -> stay.
REQ-017 PRESS_WAIT: high increments counter; counter reaching DEB_CYCLES -> HELD with press_pulse[i]=1 for exactly that transition cycle; any low sample -> IDLE, counter=0.
REQ-018 HELD: low -> RELEASE_WAIT, counter=1; high -> stay, no further pulses (unless REQ-027).
REQ-019 RELEASE_WAIT: low increments counter; counter reaching DEB_CYCLES -> IDLE; any high sample -> HELD, counter=0, no pulse.
REQ-020 Latency: btn_in high and stable from edge 0 SHALL give press_pulse[i] high after edge DEB_CYCLES+2; acc_out/acc_valid SHALL update one edge later.
REQ-021 On each cycle with any press_pulse bit set, the block SHALL add the sum of weights of all pulsing channels to acc_out (simultaneous presses summed in one cycle).
REQ-022 The sum SHALL be computed at ACC_W+$clog2(NUM_CH)+1 bits; if the result exceeds 2^ACC_W-1, acc_out SHALL hold 2^ACC_W-1 and sat SHALL set.
REQ-023 acc_valid SHALL pulse for every add cycle, including saturated adds and zero weights.
REQ-024 clear=1 SHALL set acc_out=0, sat=0, acc_valid=0 on the next edge; pulses in the same cycle SHALL be discarded; channel FSMs SHALL be unaffected.

Reset
REQ-025 resetn=0 at a rising edge SHALL set all FSMs to IDLE, counters and synchronisers to 0, press_pulse=0, acc_out=0, acc_valid=0, sat=0.
REQ-026 Reset mid-debounce or mid-hold SHALL discard the event; a button held through reset release SHALL produce a fresh press after DEB_CYCLES+2 cycles.

Configuration
REQ-027 With macro AUTO_REPEAT_EN defined, each channel in HELD SHALL count up to REPEAT_CYCLES and emit a further press_pulse[i] every REPEAT_CYCLES cycles while held, counter cleared on leaving HELD.
REQ-028 Without AUTO_REPEAT_EN, the repeat counter and logic SHALL be absent and HELD SHALL emit no pulses.

Structure
REQ-029 Package button_pkg SHALL hold the channel FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the synchroniser depth constant (2).
REQ-030 Per-channel synchroniser, FSM, counters and repeat logic SHALL live in sub-module debounce_channel, instantiated NUM_CH times by generate; accumulator and saturation logic in the top.

Verification
REQ-031 NUM_CH=2, DEB_CYCLES=100, weights 1/10: ch0 held 200 cycles -> one press_pulse[0] at cycle 102, acc_out=1 at 103, acc_valid one cycle.
REQ-032 ch0 high 60 cycles, low 5, high 150 -> no pulse during first burst, single pulse 102 cycles after second rise.
REQ-033 Both channels rising same edge, held -> press_pulse=2'b11 same cycle, acc_out 0->11 in one step.
REQ-034 ACC_W=8, weight1=10, 26 ch1 presses -> acc_out 250, then 255 with sat=1; clear -> acc_out=0, sat=0 next edge.
REQ-035 resetn low at cycle 50 of a hold -> no pulse; held after release -> pulse 102 cycles after resetn high.
REQ-036 AUTO_REPEAT_EN, REPEAT_CYCLES=20, ch0 held 170 cycles -> pulses at 102, 122, 142, 162; acc_out=4 (weight 1).
